demux1to4_buf: RTL and testbench
================================

# demux1to4_buf

Buffered 1-to-4 demultiplexer: accepts a WIDTH-bit word plus a 2-bit destination select on a single valid/ready input channel and delivers it to exactly one of four valid/ready output channels. It is the inverse of the 4-to-1 select datapath and sits on the store/write-back path, routing one producer (such as the MEM-stage store port) to one of four sinks (data memory, IO regions). A 2-entry in-order FIFO decouples producer and sinks: full throughput, registered outputs, no combinational ready path from sinks to producer.

## Interface
- WIDTH, 32, data word width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word this cycle
- in_sel  input  2  destination channel 0..3, sampled with in_data
- in_data  input  WIDTH  word to route
- out_valid  output  4  one-hot/zero; bit i = word pending for channel i
- out_ready  input  4  bit i = sink i accepts this cycle
- out_data  output  WIDTH  shared data bus, qualified by out_valid

## Operation
- Storage: 2 entries of {sel[1:0], data[WIDTH-1:0]}, write pointer, read pointer (1 bit each), occupancy count 0..2.
- States (by count): EMPTY(0), ONE(1), FULL(2).
- Push: in_valid && in_ready at clock edge -> entry written at wr_ptr, wr_ptr toggles.
- in_ready = rst_n && (count != 2). Depends only on registered state, never on out_ready.
- Head = entry at rd_ptr. When count != 0: out_valid = one-hot of head sel, out_data = head data. When count == 0: out_valid = 4'b0000, out_data = 0.
- Pop: count != 0 && out_ready[head sel] -> rd_ptr toggles. out_ready bits of non-selected channels are ignored.
- Transitions: EMPTY -push-> ONE; ONE -push only-> FULL; ONE -pop only-> EMPTY; ONE -push&pop-> ONE; FULL -pop-> ONE (no push possible in FULL, in_ready=0); otherwise hold.
- Ordering strict FIFO across all channels: a stalled head blocks later words even if their sinks are ready (head-of-line blocking is required, preserves store order).
- in_sel is 2 bits and always valid; there is no error channel.
- Reset (async assert, any time, including mid-transfer): count=0, pointers=0, out_valid=0, out_data=0, in_ready=0 while rst_n low. Buffered words are discarded. Storage contents need not be reset.
- Once out_valid[i] is asserted, out_data and out_valid must stay stable until that word pops (AXI-style stability).

## Timing
- Latency: word pushed at edge N appears on out_valid/out_data after edge N (visible in cycle N+1); earliest pop at edge N+1.
- Throughput: 1 word/cycle sustained when head sink ready every cycle (ONE state, push & pop same edge).
- FULL with pop at edge N: in_ready rises in cycle N+1 (one-cycle bubble on producer side is allowed only from FULL).
- Simultaneous push and pop in ONE: count unchanged, new word becomes head after the edge.
- Release of rst_n: first push possible at the first rising edge with rst_n high and in_valid high.

## Test plan
- Reset: hold rst_n=0 with in_valid=1, out_ready=4'hF -> out_valid=0, out_data=0, in_ready=0; release, no spurious output.
- Single transfer: push sel=2, data=0xDEADBEEF at edge N, out_ready=4'b0100 -> out_valid=4'b0100, out_data=0xDEADBEEF in cycle N+1, popped at edge N+1, out_valid=0 in N+2.
- Back-pressure: out_ready=0, push 0x11(sel0), 0x22(sel1), 0x33(sel3) on consecutive cycles -> first two accepted, in_ready=0 after second, 0x33 held by producer; out_valid=4'b0001 stable with 0x11.
- Streaming: 16 words, sel cycling 0..3, out_ready=4'hF -> one word delivered per cycle, in order, each on the correct channel, in_ready never drops.
- Head-of-line: head sel=1 with out_ready=4'b1101, next word sel=0 -> nothing pops, out_valid=4'b0010 stable; raise bit1 -> sel1 word pops, then sel0 word delivered next cycle.
- Reset mid-operation: FULL with sinks stalled, assert rst_n=0 asynchronously mid-cycle -> out_valid=0 immediately; after release block is EMPTY and first new word delivered normally.

Source files
------------

// File: rtl/demux1to4_buf.sv
// demux1to4_buf: 2-entry in-order FIFO that routes each word to one of four valid/ready sinks.
// Outputs depend only on registered state, so there is no combinational path from out_ready to in_ready.
module demux1to4_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t           state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       sel_q [2];
    logic [1:0]       sel_d [2];
    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    logic             push, pop;
    always_comb begin
        in_ready = rst_n && state_q != FULL;
        out_valid = state_q != EMPTY ? 4'(1) << sel_q[rd_ptr_q] : 4'b0000;
        out_data = state_q != EMPTY ? data_q[rd_ptr_q] : '0;
        push = in_valid && in_ready;
        // Only the head's own sink can release it; a stalled head blocks everything behind it.
        pop = state_q != EMPTY && out_ready[sel_q[rd_ptr_q]];
        sel_d = sel_q;
        data_d = data_q;
        sel_d[wr_ptr_q] = push ? in_sel : sel_q[wr_ptr_q];
        data_d[wr_ptr_q] = push ? in_data : data_q[wr_ptr_q];
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        state_d = (push && !pop) ? (state_q == EMPTY ? ONE : FULL) :
                  (pop && !push) ? (state_q == FULL ? ONE : EMPTY) : state_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        sel_q <= sel_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_demux1to4_buf.sv
// tb_demux1to4_buf: queue-based reference model checked every cycle, plus directed literal checks.
module tb_demux1to4_buf;
    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } item_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = 2'd0;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'h0;
    logic [31:0] out_data;
    item_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    demux1to4_buf #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: a plain queue of at most two words; the head goes out on its sink's channel.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else begin
            automatic bit do_push = in_valid && q.size() < 2;
            if (q.size() > 0 && out_ready[q[0].sel]) begin
                void'(q.pop_front());
                pops++;
            end
            if (do_push) q.push_back('{sel: in_sel, data: in_data});
        end
    end
    always @(negedge clk) begin
        chk("model_in_ready", 64'(in_ready), 64'(rst_n && q.size() < 2));
        chk("model_out_valid", 64'(out_valid), q.size() > 0 ? 64'(4'(1) << q[0].sel) : 64'd0);
        chk("model_out_data", 64'(out_data), q.size() > 0 ? 64'(q[0].data) : 64'd0);
    end
    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        in_valid = v;
        in_sel = s;
        in_data = d;
        out_ready = r;
    endtask
    initial begin
        drive(1'b1, 2'd0, 32'hAAAA5555, 4'hF);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 2'd0, 32'd0, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(out_valid), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0100);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 4'b0100);
        chk("single_valid", 64'(out_valid), 64'h4);
        chk("single_data", 64'(out_data), 64'hDEADBEEF);
        @(negedge clk);
        chk("single_popped", 64'(out_valid), 64'd0);
        drive(1'b1, 2'd0, 32'h11, 4'h0);
        @(negedge clk);
        chk("bp_ready_one", 64'(in_ready), 64'd1);
        drive(1'b1, 2'd1, 32'h22, 4'h0);
        @(negedge clk);
        drive(1'b1, 2'd3, 32'h33, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_full", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_data", 64'(out_data), 64'h11);
            @(negedge clk);
        end
        out_ready = 4'hF;
        @(negedge clk);
        chk("bp_drain1_valid", 64'(out_valid), 64'h2);
        chk("bp_drain1_data", 64'(out_data), 64'h22);
        chk("bp_drain1_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 4'hF);
        chk("bp_drain2_valid", 64'(out_valid), 64'h8);
        chk("bp_drain2_data", 64'(out_data), 64'h33);
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'(i), 32'h1000 + 32'(i), 4'hF);
            @(negedge clk);
            chk("stream_ready", 64'(in_ready), 64'd1);
            chk("stream_valid", 64'(out_valid), 64'(4'(1) << (i % 4)));
            chk("stream_data", 64'(out_data), 64'h1000 + 64'(i));
        end
        drive(1'b0, 2'd0, 32'd0, 4'hF);
        @(negedge clk);
        chk("stream_end", 64'(out_valid), 64'd0);
        drive(1'b1, 2'd1, 32'hA1, 4'b1101);
        @(negedge clk);
        drive(1'b1, 2'd0, 32'hB0, 4'b1101);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 4'b1101);
        for (int i = 0; i < 2; i++) begin
            chk("hol_valid", 64'(out_valid), 64'h2);
            chk("hol_data", 64'(out_data), 64'hA1);
            @(negedge clk);
        end
        out_ready = 4'hF;
        @(negedge clk);
        chk("hol_next_valid", 64'(out_valid), 64'h1);
        chk("hol_next_data", 64'(out_data), 64'hB0);
        @(negedge clk);
        chk("hol_empty", 64'(out_valid), 64'd0);
        drive(1'b1, 2'd2, 32'hC1, 4'h0);
        @(negedge clk);
        drive(1'b1, 2'd3, 32'hC2, 4'h0);
        @(negedge clk);
        chk("mid_full", 64'(in_ready), 64'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 32'h5EED, 4'b1000);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 4'b1000);
        chk("after_rst_valid", 64'(out_valid), 64'h8);
        chk("after_rst_data", 64'(out_data), 64'h5EED);
        @(negedge clk);
        chk("after_rst_empty", 64'(out_valid), 64'd0);
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom,
                  $urandom_range(0, 2) == 0 ? 4'hF : 4'($urandom));
            @(negedge clk);
        end
        drive(1'b0, 2'd0, 32'd0, 4'hF);
        repeat (3) @(negedge clk);
        chk("final_empty", 64'(out_valid), 64'd0);
        if (pops < 100) begin
            errors++;
            $display("FAIL pop_count: got %0d expected at least 100", pops);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
